// File: rtl/pipe_prefix_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined Kogge-Stone adder.
package pipe_prefix_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Accept-to-out_valid latency: input register plus one register per prefix group.
  function automatic int calc_lat(input int width, input int reg_every);
    return (clog2(width) + reg_every - 1) / reg_every + 1;
  endfunction

endpackage

// File: rtl/pipe_prefix_adder_level.sv
// One Kogge-Stone prefix level: combines (G,P) of bit i with bit i-DIST.
module prefix_level #(
  parameter int WIDTH = 68,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] g_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] p_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= DIST) begin : g_cmb
      assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-DIST]);
      assign p_o[i] = p_i[i] & p_i[i-DIST];
    end else begin : g_pass
      assign g_o[i] = g_i[i];
      assign p_o[i] = p_i[i];
    end
  end

endmodule

// File: rtl/pipe_prefix_adder.sv
// Pipelined Kogge-Stone add/sub with tag sideband and valid/ready flow control.
module pipe_prefix_adder
  import pipe_prefix_adder_pkg::*;
#(
  parameter int WIDTH     = 68,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] tag_o
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int NG     = calc_lat(WIDTH, REG_EVERY) - 1;

  // g/p evolve through the prefix levels; p0 and c0 ride along for the sum.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] p0;
    logic             c0;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [NG:0]      vld_pipe;
  stage_t [NG:0]    stq;
  stage_t [NG:0]    std;
  logic             stall;
  logic [WIDTH-1:0] bx;
  stage_t           fin;
  logic [WIDTH:0]   c;

  assign bx     = (op == OP_SUB) ? ~b : b;
  assign std[0] = '{g: a & bx, p: a ^ bx, p0: a ^ bx,
                    c0: (op == OP_SUB) ? 1'b1 : cin, tag: tag};

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    logic [WIDTH-1:0] gi, pi, go, po;
    if ((k - 1) % REG_EVERY == 0) begin : g_src_reg
      assign gi = stq[(k-1)/REG_EVERY].g;
      assign pi = stq[(k-1)/REG_EVERY].p;
    end else begin : g_src_lvl
      assign gi = g_lvl[k-1].go;
      assign pi = g_lvl[k-1].po;
    end
    prefix_level #(.WIDTH(WIDTH), .DIST(1 << (k - 1))) u_lvl (
      .g_i(gi), .p_i(pi), .g_o(go), .p_o(po)
    );
  end

  // Stage s captures the last level of its group; the tail group may be short.
  for (genvar s = 1; s <= NG; s++) begin : g_stg
    localparam int L = (s * REG_EVERY < LEVELS) ? s * REG_EVERY : LEVELS;
    assign std[s] = '{g: g_lvl[L].go, p: g_lvl[L].po, p0: stq[s-1].p0,
                      c0: stq[s-1].c0, tag: stq[s-1].tag};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      stq      <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[NG-1:0], in_valid};
      stq      <= std;
    end
  end

  assign fin       = stq[NG];
  assign c         = {fin.g | (fin.p & {WIDTH{fin.c0}}), fin.c0};
  assign sum       = fin.p0 ^ c[WIDTH-1:0];
  assign cout      = c[WIDTH];
  assign ovf       = c[WIDTH] ^ c[WIDTH-1];
  assign zero      = ~|sum;
  assign tag_o     = fin.tag;
  assign out_valid = vld_pipe[NG];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

endmodule

// File: tb/tb_pipe_prefix_adder.sv
// Randomized bench for pipe_prefix_adder against an arithmetic reference model.
module tb_pipe_prefix_adder;
  import pipe_prefix_adder_pkg::*;

  localparam int W    = 68;
  localparam int NCFG = 9;
  localparam int NSW  = 24;
  localparam int NST  = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, cin, op, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0]  a, b, sum;
  logic [3:0]    tag, tag_o;

  int vectors = 0;
  int miscompares = 0;

  pipe_prefix_adder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .zero(zero), .tag_o(tag_o)
  );

  function automatic int cfg_w(input int i);
    return (i / 3 == 0) ? 2 : (i / 3 == 1) ? 8 : 68;
  endfunction
  function automatic int cfg_r(input int i);
    return (i % 3 == 0) ? 1 : (i % 3 == 1) ? 3 : 7;
  endfunction

  logic                 sw_ordy;
  logic [NCFG-1:0]      sw_iv, sw_cin, sw_op, sw_ov, sw_ir, sw_cout, sw_ovf, sw_zero;
  logic [NCFG-1:0][67:0] sw_a, sw_b, sw_sum;
  logic [NCFG-1:0][3:0]  sw_tag, sw_tago;

  for (genvar i = 0; i < NCFG; i++) begin : g_sw
    localparam int SW = cfg_w(i);
    localparam int SR = cfg_r(i);
    logic [SW-1:0] s_sum;
    logic          s_co, s_ov, s_z, s_ir, s_vo;
    logic [3:0]    s_tg;
    pipe_prefix_adder #(.WIDTH(SW), .REG_EVERY(SR), .TAG_W(4)) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_iv[i]), .in_ready(s_ir),
      .a(sw_a[i][SW-1:0]), .b(sw_b[i][SW-1:0]), .cin(sw_cin[i]), .op(sw_op[i]),
      .tag(sw_tag[i]), .out_valid(s_vo), .out_ready(sw_ordy), .sum(s_sum),
      .cout(s_co), .ovf(s_ov), .zero(s_z), .tag_o(s_tg)
    );
    assign sw_sum[i]  = 68'(s_sum);
    assign sw_cout[i] = s_co;
    assign sw_ovf[i]  = s_ov;
    assign sw_zero[i] = s_z;
    assign sw_ov[i]   = s_vo;
    assign sw_ir[i]   = s_ir;
    assign sw_tago[i] = s_tg;
  end

  // Reference: plain w-bit integer arithmetic; returns {ovf, cout, sum}.
  function automatic logic [69:0] ref_calc(input int w, input logic [67:0] xa, xb,
                                           input logic ci, input logic sub);
    logic [68:0] m, av, bv, full;
    logic co, ov;
    m    = (69'd1 << w) - 69'd1;
    av   = {1'b0, xa} & m;
    bv   = (sub ? ~{1'b0, xb} : {1'b0, xb}) & m;
    full = av + bv + ((sub || ci) ? 69'd1 : 69'd0);
    co   = full[w];
    ov   = (av[w-1] == bv[w-1]) && (full[w-1] != av[w-1]);
    return {ov, co, full[67:0] & m[67:0]};
  endfunction

  function automatic logic [67:0] rnd68();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return 68'($urandom_range(0, 3));
      default: return r[67:0];
    endcase
  endfunction

  task automatic run_one(input logic [67:0] ia, ib, input logic ic, iop,
                         input logic [3:0] itg, output int lat);
    a = ia; b = ib; cin = ic; op = iop; tag = itg;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    vectors++;
    if (sum !== '0 || zero !== 1'b1) begin
      miscompares++; $display("FAIL reset_sum got %h zero %b want 0 zero 1", sum, zero);
    end
    vectors++;
    if ({cout, ovf, tag_o} !== 6'd0) begin
      miscompares++; $display("FAIL reset_flags got cout %b ovf %b tag %h want 0", cout, ovf, tag_o);
    end
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset got in_ready %b out_valid %b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_wrap();
    int lat;
    run_one('1, '0, 1'b1, OP_ADD, 4'h3, lat);
    vectors++;
    if (lat !== 5) begin
      miscompares++; $display("FAIL add_wrap_latency got %0d want 5", lat);
    end
    vectors++;
    if (sum !== '0 || cout !== 1'b1 || zero !== 1'b1 || ovf !== 1'b0 || tag_o !== 4'h3) begin
      miscompares++;
      $display("FAIL add_wrap got sum %h cout %b zero %b ovf %b tag %h want 0 1 1 0 3", sum, cout, zero, ovf, tag_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    int lat;
    logic [67:0] e;
    e = '1; e[0] = 1'b0;
    run_one(68'd5, 68'd7, 1'b1, OP_SUB, 4'h9, lat);
    vectors++;
    if (lat !== 5 || sum !== e || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("FAIL sub_5_7 got lat %0d sum %h cout %b ovf %b zero %b want 5 %h 0 0 0", lat, sum, cout, ovf, zero, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ovf();
    int lat;
    logic [67:0] xa, e;
    xa = '1; xa[67] = 1'b0;
    e = '0; e[67] = 1'b1;
    run_one(xa, 68'd1, 1'b0, OP_ADD, 4'hC, lat);
    vectors++;
    if (sum !== e || ovf !== 1'b1 || cout !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("FAIL add_ovf got sum %h ovf %b cout %b zero %b want %h 1 0 0", sum, ovf, cout, zero, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    logic [67:0] sa[NST], sb[NST];
    logic        sc[NST], so[NST];
    logic [69:0] r;
    logic [75:0] snap;
    logic        held, exp_ir;
    int sent, recv, cyc;
    for (int i = 0; i < NST; i++) begin
      sa[i] = rnd68(); sb[i] = rnd68();
      sc[i] = 1'($urandom); so[i] = 1'($urandom);
    end
    sent = 0; recv = 0; cyc = 0; held = 1'b0; snap = '0;
    while (recv < NST && cyc < 500) begin
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = (sent < NST) && ($urandom_range(0, 3) != 0);
      if (sent < NST) begin
        a = sa[sent]; b = sb[sent]; cin = sc[sent]; op = so[sent]; tag = sent[3:0];
      end
      #1;
      exp_ir = !(out_valid && !out_ready);
      vectors++;
      if (in_ready !== exp_ir) begin
        miscompares++; $display("FAIL stream_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_ir);
      end
      if (held) begin
        vectors++;
        if ({out_valid, cout, ovf, zero, tag_o, sum} !== snap) begin
          miscompares++;
          $display("FAIL stream_hold cyc %0d got %h want %h", cyc, {out_valid, cout, ovf, zero, tag_o, sum}, snap);
        end
      end
      if (out_valid && out_ready) begin
        r = ref_calc(W, sa[recv], sb[recv], sc[recv], so[recv]);
        vectors++;
        if ({ovf, cout, sum} !== r || zero !== (r[67:0] == '0) || tag_o !== recv[3:0]) begin
          miscompares++;
          $display("FAIL stream_result beat %0d got %h tag %h want %h tag %h", recv, {ovf, cout, sum}, tag_o, r, recv[3:0]);
        end
        recv++;
      end
      held = out_valid && !out_ready;
      snap = {out_valid, cout, ovf, zero, tag_o, sum};
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++;
    if (recv !== NST || sent !== NST) begin
      miscompares++; $display("FAIL stream_count got sent %0d recv %0d want %0d", sent, recv, NST);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++; $display("FAIL stream_extra_output cyc %0d got out_valid %b want 0", i, out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_flush();
    int n, lat;
    logic [67:0] xa, xb;
    logic [69:0] r;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rnd68(); b = rnd68(); cin = 1'b0; op = OP_ADD; tag = 4'(i);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++; $display("FAIL flush_prefill got out_valid %b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || zero !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_async got out_valid %b in_ready %b zero %b want 0 1 1", out_valid, in_ready, zero);
    end
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++; $display("FAIL flush_stale cyc %0d got out_valid %b want 0", i, out_valid);
      end
      @(posedge clk); #1;
    end
    xa = rnd68(); xb = rnd68();
    r = ref_calc(W, xa, xb, 1'b0, OP_SUB);
    run_one(xa, xb, 1'b0, OP_SUB, 4'h7, lat);
    vectors++;
    if (lat !== 5 || {ovf, cout, sum} !== r || tag_o !== 4'h7) begin
      miscompares++;
      $display("FAIL flush_after got lat %0d res %h tag %h want 5 %h 7", lat, {ovf, cout, sum}, tag_o, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    logic [67:0] ha[NCFG][NSW], hb[NCFG][NSW];
    logic        hc[NCFG][NSW], ho[NCFG][NSW];
    int          oc[NCFG], fo[NCFG];
    int          k, el;
    logic [69:0] r;
    sw_ordy = 1'b1;
    for (int i = 0; i < NCFG; i++) begin
      oc[i] = 0; fo[i] = -1;
      for (int j = 0; j < NSW; j++) begin
        ha[i][j] = rnd68(); hb[i][j] = rnd68();
        hc[i][j] = 1'($urandom); ho[i][j] = 1'($urandom);
      end
    end
    for (int t = 0; t < NSW + 20; t++) begin
      for (int i = 0; i < NCFG; i++) begin
        sw_iv[i] = (t < NSW);
        if (t < NSW) begin
          sw_a[i] = ha[i][t]; sw_b[i] = hb[i][t];
          sw_cin[i] = hc[i][t]; sw_op[i] = ho[i][t]; sw_tag[i] = t[3:0];
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < NCFG; i++) begin
        if (sw_ov[i]) begin
          if (fo[i] < 0) fo[i] = t + 1;
          k = oc[i];
          vectors++;
          if (k >= NSW) begin
            miscompares++; $display("FAIL sweep_extra cfg %0d got beat %0d want <%0d", i, k, NSW);
          end else begin
            r = ref_calc(cfg_w(i), ha[i][k], hb[i][k], hc[i][k], ho[i][k]);
            if ({sw_ovf[i], sw_cout[i], sw_sum[i]} !== r || sw_zero[i] !== (r[67:0] == '0)
                || sw_tago[i] !== k[3:0] || sw_ir[i] !== 1'b1) begin
              miscompares++;
              $display("FAIL sweep_result cfg %0d beat %0d got %h tag %h want %h tag %h", i, k,
                       {sw_ovf[i], sw_cout[i], sw_sum[i]}, sw_tago[i], r, k[3:0]);
            end
          end
          oc[i]++;
        end
      end
    end
    sw_iv = '0;
    for (int i = 0; i < NCFG; i++) begin
      el = ($clog2(cfg_w(i)) + cfg_r(i) - 1) / cfg_r(i) + 1;
      vectors++;
      if (oc[i] !== NSW || fo[i] !== el) begin
        miscompares++;
        $display("FAIL sweep_latency cfg %0d (W=%0d R=%0d) got count %0d lat %0d want %0d %0d",
                 i, cfg_w(i), cfg_r(i), oc[i], fo[i], NSW, el);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = OP_ADD; tag = '0; out_ready = 1'b1;
    sw_ordy = 1'b1; sw_iv = '0; sw_a = '0; sw_b = '0; sw_cin = '0; sw_op = '0; sw_tag = '0;
    test_reset();
    test_add_wrap();
    test_sub();
    test_ovf();
    test_stream();
    test_reset_flush();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
